// File: rtl/ftdi_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the FT60x TX stream among NUM_CH sources.
// Define FTDI_TX_ARB_HDR_EN to prefix each packet with a channel-ID header beat.
`timescale 1ns/1ps
module ftdi_tx_arbiter #(
  parameter int TDATA_WIDTH = 32,
  parameter int NUM_CH      = 4,
  localparam int CH_W       = $clog2(NUM_CH),
  localparam int KW         = TDATA_WIDTH / 8
) (
  input  logic                          usb_clk,
  input  logic                          rst_usbclk,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic [NUM_CH*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CH*KW-1:0]          s_axis_tkeep,
  input  logic [NUM_CH*KW-1:0]          s_axis_tstrb,
  input  logic [NUM_CH-1:0]             s_axis_tlast,
  input  logic [NUM_CH-1:0]             s_axis_tvalid,
  output logic [NUM_CH-1:0]             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic [KW-1:0]                 m_axis_tkeep,
  output logic [KW-1:0]                 m_axis_tstrb,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [CH_W-1:0]               grant_ch,
  output logic                          busy,
  output logic                          pkt_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_HDR  = 3'b010,
    S_DATA = 3'b100
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CH_W-1:0]        r_grant;
  logic [CH_W-1:0]        r_last_grant;
  logic                   r_busy;
  logic                   r_pkt_done;

  logic [NUM_CH-1:0]      w_req;
  logic [CH_W-1:0]        w_pick;
  logic [CH_W-1:0]        w_idx;
  logic                   w_found;
  logic [TDATA_WIDTH-1:0] w_g_data;
  logic [KW-1:0]          w_g_keep;
  logic [KW-1:0]          w_g_strb;
  logic                   w_g_last;
  logic                   w_g_valid;
  logic                   w_tl_fire;

  assign w_req = s_axis_tvalid & ch_en;

  // Search upward from the channel after the last winner, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'((32'(r_last_grant) + k) % NUM_CH);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_g_data  = s_axis_tdata[int'(r_grant)*TDATA_WIDTH +: TDATA_WIDTH];
    w_g_keep  = s_axis_tkeep[int'(r_grant)*KW +: KW];
    w_g_strb  = s_axis_tstrb[int'(r_grant)*KW +: KW];
    w_g_last  = s_axis_tlast[r_grant];
    w_g_valid = s_axis_tvalid[r_grant];
  end

`ifdef FTDI_TX_ARB_HDR_EN
  logic [TDATA_WIDTH-1:0] w_hdr;

  always_comb begin
    w_hdr = '0;
    w_hdr[TDATA_WIDTH-1 -: 16] = 16'hA55A;
    w_hdr[CH_W-1:0] = r_grant;
  end
`endif

  assign w_tl_fire = (r_state == S_DATA) & w_g_valid
                   & m_axis_tready & w_g_last;

  always_comb begin
    w_next        = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tstrb  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
`ifdef FTDI_TX_ARB_HDR_EN
          w_next = S_HDR;
`else
          w_next = S_DATA;
`endif
        end
      end
`ifdef FTDI_TX_ARB_HDR_EN
      S_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = w_hdr;
        m_axis_tkeep  = '1;
        m_axis_tstrb  = '1;
        if (m_axis_tready) w_next = S_DATA;
      end
`endif
      S_DATA: begin
        m_axis_tvalid          = w_g_valid;
        m_axis_tdata           = w_g_data;
        m_axis_tkeep           = w_g_keep;
        m_axis_tstrb           = w_g_strb;
        m_axis_tlast           = w_g_last;
        s_axis_tready[r_grant] = m_axis_tready;
        if (w_tl_fire) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (rst_usbclk) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge usb_clk) begin
    if (rst_usbclk) begin
      r_grant      <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_busy       <= 1'b0;
      r_pkt_done   <= 1'b0;
    end else begin
      r_busy     <= (w_next != S_IDLE);
      r_pkt_done <= w_tl_fire;
      if (r_state == S_IDLE && w_found) r_grant <= w_pick;
      if (w_tl_fire) r_last_grant <= r_grant;
    end
  end

  assign grant_ch = r_grant;
  assign busy     = r_busy;
  assign pkt_done = r_pkt_done;

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// Scoreboard bench for ftdi_tx_arbiter: random sources, queue-based round-robin model.
// Honours FTDI_TX_ARB_HDR_EN by expecting a channel-ID header beat per packet.
`timescale 1ns/1ps
module tb_ftdi_tx_arbiter;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int KW  = 4;
  localparam int CW  = 2;
`ifdef FTDI_TX_ARB_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic              usb_clk = 1'b0;
  logic              rst_usbclk = 1'b1;
  logic [NCH-1:0]    ch_en;
  logic [NCH*DW-1:0] s_axis_tdata;
  logic [NCH*KW-1:0] s_axis_tkeep;
  logic [NCH*KW-1:0] s_axis_tstrb;
  logic [NCH-1:0]    s_axis_tlast;
  logic [NCH-1:0]    s_axis_tvalid;
  logic [NCH-1:0]    s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [KW-1:0]     m_axis_tstrb;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [CW-1:0]     grant_ch;
  logic              busy;
  logic              pkt_done;

  always #5 usb_clk = ~usb_clk;

  ftdi_tx_arbiter #(.TDATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .usb_clk(usb_clk), .rst_usbclk(rst_usbclk), .ch_en(ch_en),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .grant_ch(grant_ch), .busy(busy), .pkt_done(pkt_done)
  );

  typedef struct packed {
    logic          first;
    logic          last;
    logic [KW-1:0] keep;
    logic [KW-1:0] strb;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [KW-1:0] strb;
    logic          last;
  } exp_t;

  beat_t src_mem [NCH][512];
  int    src_wr [NCH];
  int    src_rd [NCH];
  int    m_rd [NCH];
  int    m_last;
  exp_t  exp_q [$];
  int    pkt_log [$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    gap_en = 1'b0;
  int    rdy_mode = 0;
  int    flush_cnt = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source drivers and m_axis_tready generator
  initial begin : drv
    logic [NCH-1:0] fired;
    bit             vl [NCH];
    int             pidx;
    int             seen_flush;
    logic [4:0]     pat;
    beat_t          b;
    pat = 5'b11001;
    pidx = 0;
    seen_flush = 0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tstrb  = '0;
    s_axis_tlast  = '0;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      src_rd[i] = 0;
      vl[i] = 1'b0;
    end
    forever begin
      @(negedge usb_clk);
      fired = s_axis_tvalid & s_axis_tready;
      @(posedge usb_clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (fired[i]) begin
          src_rd[i]++;
          vl[i] = 1'b0;
        end
      end
      if (seen_flush != flush_cnt) begin
        seen_flush = flush_cnt;
        for (int i = 0; i < NCH; i++) begin
          src_rd[i] = src_wr[i];
          vl[i] = 1'b0;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (src_rd[i] < src_wr[i]) begin
          b = src_mem[i][src_rd[i]];
          s_axis_tdata[i*DW +: DW] = b.data;
          s_axis_tkeep[i*KW +: KW] = b.keep;
          s_axis_tstrb[i*KW +: KW] = b.strb;
          s_axis_tlast[i] = b.last;
          if (!vl[i])
            vl[i] = b.first || !gap_en || ($urandom_range(0, 3) != 0);
          s_axis_tvalid[i] = vl[i];
        end else begin
          s_axis_tvalid[i] = 1'b0;
          vl[i] = 1'b0;
        end
      end
      case (rdy_mode)
        1: m_axis_tready = ($urandom_range(0, 2) != 0);
        2: begin
          m_axis_tready = (pidx < 5) ? pat[pidx] : 1'b1;
          pidx++;
        end
        default: m_axis_tready = 1'b1;
      endcase
      if (rdy_mode != 2) pidx = 0;
    end
  end

  // Monitor: pops the scoreboard on every accepted m_axis beat
  initial begin : mon
    bit   tl1, tl2, in_pkt;
    exp_t e, a;
    tl1 = 1'b0;
    tl2 = 1'b0;
    in_pkt = 1'b0;
    forever begin
      @(negedge usb_clk);
      if (rst_usbclk) begin
        tl1 = 1'b0;
        tl2 = 1'b0;
        in_pkt = 1'b0;
      end else begin
        if (busy) begin
          check("other_ready", s_axis_tready & ~(4'b0001 << grant_ch), 0);
          check("ready_vs_m", s_axis_tready[grant_ch] & ~m_axis_tready, 0);
        end
        if (tl1)
          check("post_tlast", {pkt_done, m_axis_tvalid, busy}, 3'b100);
        else if (pkt_done)
          check("stray_pkt_done", pkt_done, 0);
        if (tl2 && exp_q.size() != 0)
          check("rearb_busy", busy, 1);
        tl2 = tl1;
        tl1 = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          a = {grant_ch, m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast};
          if (!in_pkt) pkt_log.push_back(int'(grant_ch));
          in_pkt = !m_axis_tlast;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", a, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat", a, e);
          end
          tl1 = m_axis_tlast;
        end
      end
    end
  end

  task automatic step();
    @(posedge usb_clk);
    #2;
  endtask

  task automatic load_pkt(input int ch, input int len,
                          input logic [DW-1:0] base, input bit rnd);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.first = (j == 0);
      b.last  = (j == len - 1);
      b.data  = rnd ? DW'($urandom) : base + DW'(j);
      b.keep  = rnd ? KW'($urandom) : '1;
      b.strb  = rnd ? KW'($urandom) : '1;
      src_mem[ch][src_wr[ch]] = b;
      src_wr[ch]++;
    end
  endtask

  // Reference: whole packets, round-robin over enabled channels with work
  task automatic model_arb(input logic [NCH-1:0] mask);
    int    c;
    bit    found;
    exp_t  e;
    beat_t b;
    forever begin
      found = 1'b0;
      c = 0;
      for (int k = 1; k <= NCH; k++) begin
        if (!found && mask[(m_last + k) % NCH]
            && m_rd[(m_last + k) % NCH] < src_wr[(m_last + k) % NCH]) begin
          found = 1'b1;
          c = (m_last + k) % NCH;
        end
      end
      if (!found) break;
      if (HDR != 0) begin
        e.ch = CW'(c);
        e.data = 32'hA55A0000 | DW'(c);
        e.keep = '1;
        e.strb = '1;
        e.last = 1'b0;
        exp_q.push_back(e);
      end
      do begin
        b = src_mem[c][m_rd[c]];
        m_rd[c]++;
        e.ch = CW'(c);
        e.data = b.data;
        e.keep = b.keep;
        e.strb = b.strb;
        e.last = b.last;
        exp_q.push_back(e);
      end while (!b.last);
      m_last = c;
    end
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 4000; c++) begin
      step();
      if (exp_q.size() == 0 && !busy && !pkt_done) begin
        step();
        step();
        return;
      end
    end
    check({name, "_timeout"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int base, bc, pd, s0, s3, n;
    logic [NCH-1:0] mask;
    ch_en = '0;
    m_last = NCH - 1;
    for (int i = 0; i < NCH; i++) begin
      src_wr[i] = 0;
      m_rd[i] = 0;
    end
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check("rst_grant", grant_ch, 0);
    rst_usbclk = 1'b0;
    step();

    // all channels, two 3-beat packets each
    base = pkt_log.size();
    for (int c = 0; c < NCH; c++)
      for (int p = 0; p < 2; p++)
        load_pkt(c, 3, DW'(32'h100 * (c + 1) + 32'h10 * p), 1'b0);
    step();
    ch_en = 4'hF;
    model_arb(4'hF);
    drain("rr");
    for (int k = 0; k < 8; k++)
      check("rr_order", (base + k < pkt_log.size()) ? pkt_log[base + k] : -1, k % NCH);

    // single channel 1
    ch_en = '0;
    load_pkt(1, 4, 32'h11, 1'b0);
    step();
    ch_en = 4'b0010;
    model_arb(4'b0010);
    bc = 0;
    pd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      bc += int'(busy);
      pd += int'(pkt_done);
    end
    check("single_busy_cycles", bc, 4 + HDR);
    check("single_pkt_done", pd, 1);
    check("single_grant", grant_ch, 1);
    drain("single");

    // backpressure on channel 2
    ch_en = '0;
    load_pkt(2, 3, 32'h21, 1'b0);
    step();
    ch_en = 4'b0100;
    rdy_mode = 2;
    model_arb(4'b0100);
    drain("bp");
    rdy_mode = 0;
    check("bp_grant", grant_ch, 2);

    // ch0 disabled with valid, ch3 granted, ch_en[3] cleared mid-packet
    ch_en = '0;
    load_pkt(0, 2, 32'h31, 1'b0);
    load_pkt(3, 4, 32'h3A, 1'b0);
    s3 = src_wr[3] - 4;
    step();
    ch_en = 4'b1000;
    model_arb(4'b1000);
    for (int c = 0; c < 200 && src_rd[3] <= s3; c++) step();
    check("en_ch3_started", src_rd[3] > s3, 1);
    ch_en = '0;
    drain("en");
    check("en_grant3", pkt_log[pkt_log.size() - 1], 3);
    ch_en = 4'hF;
    model_arb(4'hF);
    drain("en0");
    check("en_grant0", pkt_log[pkt_log.size() - 1], 0);

    // reset during beat 2 of a 5-beat packet
    ch_en = '0;
    load_pkt(0, 5, 32'h51, 1'b0);
    s0 = src_wr[0] - 5;
    step();
    ch_en = 4'b0001;
    model_arb(4'b0001);
    for (int c = 0; c < 200 && src_rd[0] < s0 + 2; c++) step();
    check("rst_beat2_reached", src_rd[0] >= s0 + 2, 1);
    rst_usbclk = 1'b1;
    ch_en = '0;
    step();
    check("mid_rst_ready", s_axis_tready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant_ch, 0);
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    flush_cnt++;
    exp_q.delete();
    for (int i = 0; i < NCH; i++) m_rd[i] = src_wr[i];
    m_last = NCH - 1;
    step();
    step();
    rst_usbclk = 1'b0;
    step();
    base = pkt_log.size();
    load_pkt(0, 2, 32'h61, 1'b0);
    load_pkt(1, 2, 32'h71, 1'b0);
    step();
    ch_en = 4'b0011;
    model_arb(4'b0011);
    drain("post_rst");
    check("post_rst_first", (base < pkt_log.size()) ? pkt_log[base] : -1, 0);
    check("post_rst_second", (base + 1 < pkt_log.size()) ? pkt_log[base + 1] : -1, 1);

    // randomized rounds
    gap_en = 1'b1;
    rdy_mode = 1;
    for (int r = 0; r < 8; r++) begin
      mask = NCH'($urandom_range(1, 15));
      ch_en = '0;
      for (int c = 0; c < NCH; c++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++)
          load_pkt(c, $urandom_range(1, 6), '0, 1'b1);
      end
      step();
      ch_en = mask;
      model_arb(mask);
      drain("rand");
    end
    ch_en = 4'hF;
    model_arb(4'hF);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ftdi_tx_arbiter.md
Name: ftdi_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single FT60x TX path among NUM_CH user AXI-Stream sources.
- Sits in the usb_clk domain, upstream of the FT60x FIFO driver's s_axis slave port.
- Once a channel is granted, it holds the grant until that channel's tlast beat is accepted, so packets are never interleaved on the USB link.
- Optional channel-ID header beat lets host software demultiplex the packets.

Parameters:
- TDATA_WIDTH, 32, data width in bits; must be 16 or 32 to match FT600/FT601.
- NUM_CH, 4, number of source channels, 2..8. Derived localparam CH_W = clog2(NUM_CH).

Ports:
- usb_clk  in  1  FT60x clock; single clock of the block.
- rst_usbclk  in  1  synchronous reset, active-high.
- ch_en  in  NUM_CH  per-channel arbitration enable.
- s_axis_tdata  in  NUM_CH*TDATA_WIDTH  channel i at [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_tkeep  in  NUM_CH*TDATA_WIDTH/8  per-channel keep.
- s_axis_tstrb  in  NUM_CH*TDATA_WIDTH/8  per-channel strobe.
- s_axis_tlast  in  NUM_CH  per-channel last.
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tready  out  NUM_CH  per-channel ready.
- m_axis_tdata  out  TDATA_WIDTH  to FIFO driver.
- m_axis_tkeep  out  TDATA_WIDTH/8  to FIFO driver.
- m_axis_tstrb  out  TDATA_WIDTH/8  to FIFO driver.
- m_axis_tlast  out  1  to FIFO driver.
- m_axis_tvalid  out  1  to FIFO driver.
- m_axis_tready  in  1  from FIFO driver.
- grant_ch  out  CH_W  currently or last granted channel.
- busy  out  1  high while in S_HDR or S_DATA.
- pkt_done  out  1  one-cycle pulse when a tlast beat is accepted on m_axis.

Behaviour:
- Reset values (synchronous, rst_usbclk=1 sampled on usb_clk):
  - state = S_IDLE; grant_ch = 0; last_grant = NUM_CH-1, so ch0 has first priority.
  - busy = 0; pkt_done = 0; m_axis_tvalid = 0; s_axis_tready = 0.
- Request vector: req[i] = s_axis_tvalid[i] & ch_en[i].
- States are one-hot: S_IDLE, S_HDR, S_DATA.
- S_IDLE:
  - m_axis_tvalid = 0 and all s_axis_tready = 0.
  - If req != 0: grant_ch <= first set req bit searching upward from (last_grant+1) mod NUM_CH, with wrap-around.
  - Next state is S_HDR if the header is enabled, otherwise S_DATA.
  - Arbitration costs exactly one cycle. Minimum gap between packets is one idle cycle on m_axis.
- S_DATA:
  - Combinational mux from channel g = grant_ch to m_axis: m_axis_tdata/tkeep/tstrb/tlast/tvalid = channel g's signals.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready = 0.
  - On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: last_grant <= g, pkt_done <= 1 for one cycle, state <= S_IDLE.
  - The grant is held until tlast. Deasserting ch_en[g] or s_axis_tvalid[g] mid-packet does not end the grant; m_axis_tvalid simply follows s_axis_tvalid[g].
- Fairness:
  - A channel that just completed a packet has lowest priority in the next arbitration.
  - With all channels requesting, grants rotate 0,1,2,...,NUM_CH-1,0.
  - A single requesting channel is re-granted back-to-back, with one idle cycle between packets.
- Simultaneous events:
  - New tvalid on other channels during S_DATA is ignored until the return to S_IDLE.
  - A tlast beat and an m_axis_tready stall in the same cycle means no transfer and no state change.
- Reset mid-packet: on the next edge all readies drop to 0 and state goes to S_IDLE. The partial packet is abandoned; the source must restart it.
- busy is registered and equals (state != S_IDLE).
- AXI rule: m_axis_tvalid never depends on m_axis_tready.

Optional Feature:
- Macro: FTDI_TX_ARB_HDR_EN.
- Defined:
  - After arbitration the block enters S_HDR and drives one header beat: m_axis_tvalid = 1, m_axis_tdata = {16'hA55A, (TDATA_WIDTH-16) zero bits} with grant_ch OR-ed into bits [CH_W-1:0] (for TDATA_WIDTH=16, bits [15:CH_W] = 16'hA55A[15:CH_W]), tkeep/tstrb = all ones, tlast = 0.
  - All s_axis_tready = 0 in S_HDR.
  - Moves to S_DATA on m_axis_tready. The header holds stable while stalled.
- Undefined: S_HDR is not built; S_IDLE goes directly to S_DATA.

Test Plan:
- Single channel: ch1 sends a 4-beat packet 0x11..0x14, m_axis_tready=1 -> m_axis carries 4 beats with tlast on 0x14, grant_ch=1, one pkt_done pulse, busy high for 4 cycles (5 with the header).
- Round-robin: all 4 channels each hold 2 packets of 3 beats -> grant order 0,1,2,3,0,1,2,3; no interleaved beats; exactly one idle cycle between packets.
- Backpressure: ch2 sends 3 beats while m_axis_tready toggles 1,0,0,1,1 -> data matches in order; s_axis_tready[2] mirrors m_axis_tready; other readies stay 0.
- ch_en: ch0 disabled with valid high and ch3 requesting -> ch3 is granted; ch_en[3] cleared mid-packet -> packet completes.
- Reset mid-packet: assert rst_usbclk on beat 2 of 5 -> next cycle all readies = 0, busy = 0, grant_ch = 0; after release with ch0 and ch1 requesting, ch0 is granted first.
- FTDI_TX_ARB_HDR_EN defined, TDATA_WIDTH=32, ch3 granted -> first m_axis beat = 0xA55A0003 with tlast=0, followed by the payload.
